seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 94 +++++++++
 tb/tb_seq_detect_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with overlap control and a saturating match counter.
// Define SEQ_DETECT_MASK_EN to add a per-bit don't-care mask input (pattern_mask).
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inp_valid,
  input  logic             inp_bit,
  input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [PAT_W-1:0] pattern_mask,
`endif
  input  logic             overlap,
  input  logic             clear,
  output logic             seq_seen,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [PAT_W-1:0] r_pat_q;
  logic             r_seen;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic [PAT_W-1:0] w_hist_next;
  logic [PAT_W-1:0] w_care;
  logic [FW-1:0]    w_fill_inc;
  logic             w_pat_chg;
  logic             w_acc;
  logic             w_cmp;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_next;

`ifdef SEQ_DETECT_MASK_EN
  logic [PAT_W-1:0] r_mask_q;
  assign w_care    = pattern_mask;
  assign w_pat_chg = (pattern != r_pat_q) || (pattern_mask != r_mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_mask_q <= '0;
    else          r_mask_q <= pattern_mask;
  end
`else
  assign w_care    = '1;
  assign w_pat_chg = (pattern != r_pat_q);
`endif

  assign w_hist_next = {r_hist[PAT_W-2:0], inp_bit};
  assign w_fill_inc  = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
  assign w_cmp       = ((w_hist_next ^ pattern) & w_care) == '0;
  // A pattern change invalidates the history, so the bit arriving with it is dropped.
  assign w_acc       = inp_valid && !w_pat_chg;
  assign w_match     = w_acc && (w_fill_inc == FILL_FULL) && w_cmp;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clear)                  w_cnt_next = '0;
    else if (w_match && !r_sat) w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat_q <= '0;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_pat_q <= pattern;
      r_seen  <= w_match;
      r_cnt   <= w_cnt_next;
      r_sat   <= &w_cnt_next;
      if (w_pat_chg) begin
        r_fill <= '0;
      end else if (w_acc) begin
        r_hist <= w_hist_next;
        r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
      end
    end
  end

  assign seq_seen    = r_seen;
  assign match_count = r_cnt;
  assign count_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomized + directed bench for seq_detect_param against a queue-based reference model.
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       inp_valid = 1'b0, inp_bit = 1'b0, overlap = 1'b0, clear = 1'b0;
  logic [3:0] pattern = 4'h0;
`ifdef SEQ_DETECT_MASK_EN
  logic [3:0] pattern_mask = 4'hF;
`endif
  logic       seen_a, sat_a, seen_b, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int errors = 0, checks = 0;

  // reference model: accepted bits since last flush, latest at back
  int         mq[$];
  logic [3:0] m_pat_prev;
  logic [3:0] m_mask_prev;
  logic       m_seen;
  int         m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .pattern(pattern),
`ifdef SEQ_DETECT_MASK_EN
    .pattern_mask(pattern_mask),
`endif
    .overlap(overlap), .clear(clear),
    .seq_seen(seen_a), .match_count(cnt_a), .count_sat(sat_a));

  seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .inp_valid(inp_valid), .inp_bit(inp_bit),
    .pattern(pattern),
`ifdef SEQ_DETECT_MASK_EN
    .pattern_mask(pattern_mask),
`endif
    .overlap(overlap), .clear(clear),
    .seq_seen(seen_b), .match_count(cnt_b), .count_sat(sat_b));

  task automatic model_reset();
    mq.delete();
    m_pat_prev = 4'h0; m_mask_prev = 4'h0;
    m_seen = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_edge();
    logic [3:0] care;
    logic chg, m;
`ifdef SEQ_DETECT_MASK_EN
    care = pattern_mask;
`else
    care = 4'hF;
`endif
    chg = (pattern != m_pat_prev) || (care != m_mask_prev);
    m_pat_prev = pattern; m_mask_prev = care;
    m = 1'b0;
    if (chg) mq.delete();
    else if (inp_valid) begin
      mq.push_back(int'(inp_bit));
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() == 4) begin
        m = 1'b1;
        for (int i = 0; i < 4; i++)
          if (care[3-i] && (mq[i] != int'(pattern[3-i]))) m = 1'b0;
        if (m && !overlap) mq.delete();
      end
    end
    m_seen = m;
    if (clear) begin m_cnt_a = 0; m_cnt_b = 0; end
    else if (m) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
  endtask

  // One clock: drive, let the edge happen, update model, settle.
  task automatic step(input logic v, input logic b, input logic clr);
    inp_valid = v; inp_bit = b; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    inp_valid = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #4;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (seen_a !== 1'b0) begin errors++; $display("FAIL reset_seen: got %b want 0", seen_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    checks++; if (sat_b !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_b); end
    reset_n = 1'b1;
    pattern = 4'b1111; overlap = 1'b1;
    step(0, 0, 0);
    repeat (4) step(1, 1, 0);
    checks++; if (seen_a !== 1'b1) begin errors++; $display("FAIL reset_pre_seen: got %b want 1", seen_a); end
    // async assertion must clear outputs without a clock edge
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (seen_a !== 1'b0) begin errors++; $display("FAIL async_seen: got %b want 0", seen_a); end
    checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL async_cnt: got %0d want 0", cnt_a); end
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_overlap_off();
    logic [6:0] bits, exp;
    bits = 7'b1011011; exp = 7'b0001000;
    apply_reset();
    pattern = 4'b1011; overlap = 1'b0;
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, bits[6-i], 0);
      checks++;
      if (seen_a !== exp[6-i]) begin errors++; $display("FAIL ovl0_seen bit%0d: got %b want %b", i+1, seen_a, exp[6-i]); end
    end
    checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL ovl0_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_overlap_on();
    logic [6:0] bits, exp;
    bits = 7'b1011011; exp = 7'b0001001;
    apply_reset();
    pattern = 4'b1011; overlap = 1'b1;
    step(0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1, bits[6-i], 0);
      checks++;
      if (seen_a !== exp[6-i]) begin errors++; $display("FAIL ovl1_seen bit%0d: got %b want %b", i+1, seen_a, exp[6-i]); end
    end
    checks++; if (cnt_a !== 8'd2) begin errors++; $display("FAIL ovl1_cnt: got %0d want 2", cnt_a); end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1011;
    apply_reset();
    pattern = 4'b1011; overlap = 1'b0;
    step(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, bits[3-k], 0);
      checks++;
      if (seen_a !== (k == 3)) begin errors++; $display("FAIL gap_seen bit%0d: got %b want %b", k+1, seen_a, (k == 3)); end
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 0);
        checks++;
        if (seen_a !== 1'b0) begin errors++; $display("FAIL gap_idle bit%0d gap%0d: got %b want 0", k+1, g, seen_a); end
      end
    end
    checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL gap_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_saturate();
    int pulses;
    apply_reset();
    pattern = 4'b1111; overlap = 1'b1;
    step(0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0);
      if (seen_b === 1'b1) pulses++;
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL sat_pulses: got %0d want 5", pulses); end
    checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_cnt_b: got %0d want 3", cnt_b); end
    checks++; if (sat_b !== 1'b1) begin errors++; $display("FAIL sat_flag_b: got %b want 1", sat_b); end
    checks++; if (cnt_a !== 8'd5 || sat_a !== 1'b0) begin errors++; $display("FAIL sat_cnt_a: got %0d/%b want 5/0", cnt_a, sat_a); end
    step(0, 0, 1);
    checks++; if (cnt_b !== 2'd0 || sat_b !== 1'b0) begin errors++; $display("FAIL clear: got %0d/%b want 0/0", cnt_b, sat_b); end
    step(1, 1, 1);
    checks++; if (seen_b !== 1'b1) begin errors++; $display("FAIL clear_match_seen: got %b want 1", seen_b); end
    checks++; if (cnt_b !== 2'd0 || cnt_a !== 8'd0) begin errors++; $display("FAIL clear_match_cnt: got %0d/%0d want 0/0", cnt_b, cnt_a); end
    step(1, 1, 0);
    checks++; if (cnt_b !== 2'd1) begin errors++; $display("FAIL post_clear_cnt: got %0d want 1", cnt_b); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits;
    bits = 4'b1011;
    apply_reset();
    pattern = 4'b1011; overlap = 1'b0;
    step(0, 0, 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    apply_reset();
    step(1, 1, 0);
    checks++; if (seen_a !== 1'b0) begin errors++; $display("FAIL rstmid_nomatch: got %b want 0", seen_a); end
    for (int i = 0; i < 4; i++) step(1, bits[3-i], 0);
    checks++; if (seen_a !== 1'b1) begin errors++; $display("FAIL rstmid_match: got %b want 1", seen_a); end
    // history 1,0,1 under 0011; switching to 1011 with the final 1 must not match
    pattern = 4'b0011;
    step(0, 0, 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    pattern = 4'b1011;
    step(1, 1, 0);
    checks++; if (seen_a !== 1'b0) begin errors++; $display("FAIL patchg_nomatch: got %b want 0", seen_a); end
    for (int i = 0; i < 4; i++) step(1, bits[3-i], 0);
    checks++; if (seen_a !== 1'b1) begin errors++; $display("FAIL patchg_rematch: got %b want 1", seen_a); end
  endtask

`ifdef SEQ_DETECT_MASK_EN
  task automatic test_mask();
    logic [3:0] bits;
    bits = 4'b1001;
    apply_reset();
    pattern = 4'b1011; pattern_mask = 4'b1101; overlap = 1'b0;
    step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, bits[3-i], 0);
    checks++; if (seen_a !== 1'b1) begin errors++; $display("FAIL mask_match: got %b want 1", seen_a); end
    pattern_mask = 4'hF;
    step(0, 0, 0);
  endtask
`endif

  task automatic test_random();
    apply_reset();
    pattern = 4'($urandom_range(0, 15)); overlap = 1'($urandom_range(0, 1));
    step(0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) apply_reset();
      if ($urandom_range(0, 19) == 0) pattern = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) overlap = ~overlap;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0));
      checks++;
      if (seen_a !== m_seen || seen_b !== m_seen) begin
        errors++; $display("FAIL rnd_seen cyc%0d: got %b/%b want %b", n, seen_a, seen_b, m_seen);
      end
      checks++;
      if (cnt_a !== 8'(m_cnt_a) || sat_a !== (m_cnt_a == 255)) begin
        errors++; $display("FAIL rnd_cnt_a cyc%0d: got %0d/%b want %0d", n, cnt_a, sat_a, m_cnt_a);
      end
      checks++;
      if (cnt_b !== 2'(m_cnt_b) || sat_b !== (m_cnt_b == 3)) begin
        errors++; $display("FAIL rnd_cnt_b cyc%0d: got %0d/%b want %0d", n, cnt_b, sat_b, m_cnt_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_off();
    test_overlap_on();
    test_gaps();
    test_saturate();
    test_reset_mid();
`ifdef SEQ_DETECT_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
